// File: rtl/lw_sha_pkg.sv
// Shared definitions for the lightweight SHA-256/224 core: round constants,
// masked buffer word format and the schedule helper functions.
package lw_sha_pkg;

  localparam int unsigned SHA_WORD_SIZE = 32;
  localparam int unsigned SHA_ROT_W     = $clog2(SHA_WORD_SIZE);
  localparam int unsigned SHA_ROUNDS    = 64;
  localparam int unsigned SHA_BUF_DEPTH = 16;

  // Stored schedule word: rotation amount plus the word rotated right by it.
  typedef struct packed {
    logic [SHA_ROT_W-1:0]     rot;
    logic [SHA_WORD_SIZE-1:0] data;
  } masked_word_t;

  localparam logic [SHA_WORD_SIZE-1:0] k [SHA_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Shift by 32 yields zero, so n == 0 degenerates cleanly to x.
  function automatic logic [SHA_WORD_SIZE-1:0] right_rotate(
    input logic [SHA_WORD_SIZE-1:0] x, input logic [SHA_ROT_W-1:0] n);
    return (x >> n) | (x << (6'd32 - 6'(n)));
  endfunction

  function automatic logic [SHA_WORD_SIZE-1:0] left_rotate(
    input logic [SHA_WORD_SIZE-1:0] x, input logic [SHA_ROT_W-1:0] n);
    return (x << n) | (x >> (6'd32 - 6'(n)));
  endfunction

  function automatic logic [SHA_WORD_SIZE-1:0] sigma0_256(input logic [SHA_WORD_SIZE-1:0] x);
    return right_rotate(x, 5'd7) ^ right_rotate(x, 5'd18) ^ (x >> 3);
  endfunction

  function automatic logic [SHA_WORD_SIZE-1:0] sigma1_256(input logic [SHA_WORD_SIZE-1:0] x);
    return right_rotate(x, 5'd17) ^ right_rotate(x, 5'd19) ^ (x >> 10);
  endfunction

  function automatic masked_word_t write_word(
    input logic [SHA_WORD_SIZE-1:0] x, input logic [SHA_ROT_W-1:0] rnd);
    masked_word_t m;
    m.rot  = rnd;
    m.data = right_rotate(x, rnd);
    return m;
  endfunction

  function automatic logic [SHA_WORD_SIZE-1:0] read_word(input masked_word_t m);
    return left_rotate(m.data, m.rot);
  endfunction

endpackage

// File: rtl/lw_sha_sched_buf.sv
// 16-entry masked register file: one write port, four decoded read ports.
module lw_sha_sched_buf
  import lw_sha_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [3:0]               waddr,
  input  masked_word_t             wdata,
  input  logic [3:0]               raddr0,
  input  logic [3:0]               raddr1,
  input  logic [3:0]               raddr2,
  input  logic [3:0]               raddr3,
  output logic [SHA_WORD_SIZE-1:0] rdata0,
  output logic [SHA_WORD_SIZE-1:0] rdata1,
  output logic [SHA_WORD_SIZE-1:0] rdata2,
  output logic [SHA_WORD_SIZE-1:0] rdata3
);

  masked_word_t mem [SHA_BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SHA_BUF_DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only unmasked on the read path; the stored form never holds plain words.
  assign rdata0 = read_word(mem[raddr0]);
  assign rdata1 = read_word(mem[raddr1]);
  assign rdata2 = read_word(mem[raddr2]);
  assign rdata3 = read_word(mem[raddr3]);

endmodule

// File: rtl/lw_sha_msg_sched.sv
// SHA-256/224 message schedule: loads 16 words, emits W[t] and W[t]+K[t]
// for t = 0..63 over a valid/ready handshake.
module lw_sha_msg_sched
  import lw_sha_pkg::*;
#(
  parameter int unsigned WORD_SIZE = SHA_WORD_SIZE,
  parameter int unsigned ROUNDS    = SHA_ROUNDS,
  parameter int unsigned ROT_W     = $clog2(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROT_W-1:0]     rnd_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WORD_SIZE-1:0] in_data_i,
  output logic                 wk_valid_o,
  input  logic                 wk_ready_i,
  output logic [WORD_SIZE-1:0] w_o,
  output logic [WORD_SIZE-1:0] wk_o,
  output logic [5:0]           round_o,
  output logic                 last_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = $clog2(SHA_BUF_DEPTH);
  localparam int unsigned T_W   = $clog2(ROUNDS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [T_W-1:0]     t;

  logic                 accept;
  logic                 advance;
  logic                 load_out;
  logic                 buf_we;
  logic [CNT_W-1:0]     buf_waddr;
  masked_word_t         buf_wdata;
  logic [WORD_SIZE-1:0] w_m2, w_m7, w_m15, w_m16;
  logic [WORD_SIZE-1:0] w_next;

  lw_sha_sched_buf u_buf (
    .clk    (clk),
    .rst    (rst),
    .we     (buf_we),
    .waddr  (buf_waddr),
    .wdata  (buf_wdata),
    .raddr0 (t[CNT_W-1:0] - 4'd2),
    .raddr1 (t[CNT_W-1:0] - 4'd7),
    .raddr2 (t[CNT_W-1:0] - 4'd15),
    .raddr3 (t[CNT_W-1:0]),
    .rdata0 (w_m2),
    .rdata1 (w_m7),
    .rdata2 (w_m15),
    .rdata3 (w_m16)
  );

  // Next schedule word and the single buffer write port arbitration.
  always_comb begin
    accept    = in_valid_i && in_ready_o && (state != S_RUN);
    advance   = (state == S_RUN) && (!wk_valid_o || wk_ready_i);
    load_out  = advance && !(wk_valid_o && last_o);
    w_next    = (t < T_W'(SHA_BUF_DEPTH)) ? w_m16
              : sigma1_256(w_m2) + w_m7 + sigma0_256(w_m15) + w_m16;
    buf_we    = 1'b0;
    buf_waddr = cnt;
    buf_wdata = write_word(in_data_i, rnd_i);
    if (accept) begin
      buf_we = 1'b1;
    end else if (load_out && (t >= T_W'(SHA_BUF_DEPTH))) begin
      buf_we    = 1'b1;
      buf_waddr = t[CNT_W-1:0];
      buf_wdata = write_word(w_next, rnd_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      t          <= '0;
      in_ready_o <= 1'b1;
      wk_valid_o <= 1'b0;
      w_o        <= '0;
      wk_o       <= '0;
      round_o    <= '0;
      last_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            cnt    <= cnt + 4'd1;
            busy_o <= 1'b1;
            if (cnt == CNT_W'(SHA_BUF_DEPTH - 1)) begin
              state      <= S_RUN;
              t          <= '0;
              in_ready_o <= 1'b0;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_RUN: begin
          // Last word already handed off: close the block and reopen input.
          if (advance && wk_valid_o && last_o) begin
            state      <= S_IDLE;
            wk_valid_o <= 1'b0;
            last_o     <= 1'b0;
            busy_o     <= 1'b0;
            in_ready_o <= 1'b1;
          end else if (load_out) begin
            w_o        <= w_next;
            wk_o       <= w_next + k[t];
            round_o    <= t;
            last_o     <= (t == T_W'(ROUNDS - 1));
            wk_valid_o <= 1'b1;
            t          <= t + 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lw_sha_msg_sched.sv
// Scoreboard bench for lw_sha_msg_sched against a plain SHA-256 schedule model.
module tb_lw_sha_msg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rnd_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic        wk_valid_o;
  logic        wk_ready_i;
  logic [31:0] w_o;
  logic [31:0] wk_o;
  logic [5:0]  round_o;
  logic        last_o;
  logic        busy_o;

  lw_sha_msg_sched u_dut (
    .clk        (clk),
    .rst        (rst),
    .rnd_i      (rnd_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .wk_valid_o (wk_valid_o),
    .wk_ready_i (wk_ready_i),
    .w_o        (w_o),
    .wk_o       (wk_o),
    .round_o    (round_o),
    .last_o     (last_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] wk;
    logic [5:0]  round;
    logic        last;
  } exp_t;

  logic [31:0] kc [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0] abc_w16 [5] = '{32'h61626380, 32'h000f0000, 32'h7da86405, 32'h600003c6, 32'h3e9d7b78};

  exp_t        q[$];
  exp_t        e;
  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];
  logic [31:0] got_wk[64];
  logic [31:0] ref_w [64];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          hs_count, first_cyc, last_cyc;
  int          cyc = 0;
  bit          seen_last, stall_mode, rnd_fixed_en, held;
  logic [4:0]  rnd_fixed;
  logic [31:0] h_w, h_wk;
  logic [5:0]  h_r;
  logic        h_l;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  always @(posedge clk) cyc++;

  // Random mask amount, or a forced one, changed away from the active edge.
  initial begin
    rnd_i = '0;
    forever begin
      @(negedge clk);
      rnd_i = rnd_fixed_en ? rnd_fixed : 5'($urandom);
    end
  end

  initial begin
    wk_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      wk_ready_i = stall_mode ? 1'($urandom) : 1'b1;
    end
  end

  // Monitor: pops expected entries on every handshake, checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (wk_valid_o) begin
      check("in_ready_in_run", 64'(in_ready_o), 64'(0));
      if (held) check("stall_hold", {w_o, wk_o}, {h_w, h_wk});
      if (held) check("stall_hold_rl", 64'({round_o, last_o}), 64'({h_r, h_l}));
      if (wk_ready_i) begin
        held = 1'b0;
        if (q.size() == 0) begin
          check("unexpected_output", 64'(round_o), 64'hffff);
        end else begin
          e = q.pop_front();
          check("w", 64'(w_o), 64'(e.w));
          check("wk", 64'(wk_o), 64'(e.wk));
          check("round", 64'(round_o), 64'(e.round));
          check("last", 64'(last_o), 64'(e.last));
          got_w[round_o]  = w_o;
          got_wk[round_o] = wk_o;
          hs_count++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (last_o) seen_last = 1'b1;
        end
      end else begin
        held = 1'b1;
        h_w = w_o; h_wk = wk_o; h_r = round_o; h_l = last_o;
      end
    end else begin
      held = 1'b0;
    end
  end

  // Reference: textbook SHA-256 message expansion on the current block.
  task automatic push_expected();
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
      s1 = rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
      exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
    end
    for (int i = 0; i < 64; i++) begin
      q.push_back('{w: exp_w[i], wk: exp_w[i] + kc[i], round: 6'(i), last: (i == 63)});
      got_w[i]  = 'x;
      got_wk[i] = 'x;
    end
    seen_last = 1'b0;
    hs_count  = 0;
    first_cyc = -1;
  endtask

  task automatic load_words(input int gap_after, input int gap_len, input bit garbage);
    for (int i = 0; i < 16; i++) begin
      if (gap_len > 0 && i == gap_after) begin
        in_valid_i = 1'b0;
        repeat (gap_len) begin
          @(posedge clk); #1;
          check("busy_gap", 64'(busy_o), 64'(1));
          check("in_ready_gap", 64'(in_ready_o), 64'(1));
        end
      end
      in_valid_i = 1'b1;
      in_data_i  = blk[i];
      @(posedge clk); #1;
      if (i < 15) check("busy_load", 64'(busy_o), 64'(1));
    end
    check("in_ready_drop", 64'(in_ready_o), 64'(0));
    in_valid_i = garbage;
    in_data_i  = $urandom;
    @(posedge clk); #1;
    check("latency_valid", 64'(wk_valid_o), 64'(1));
  endtask

  task automatic wait_done(input bit garbage);
    for (int c = 0; c < 2000 && !seen_last; c++) begin
      @(posedge clk); #1;
      if (garbage) in_data_i = $urandom;
    end
    in_valid_i = 1'b0;
    check("block_done", 64'(seen_last), 64'(1));
    check("end_in_ready", 64'(in_ready_o), 64'(1));
    check("end_valid_drop", 64'(wk_valid_o), 64'(0));
    check("end_busy", 64'(busy_o), 64'(0));
    check("handshakes", 64'(hs_count), 64'(64));
    if (!stall_mode) check("consecutive", 64'(last_cyc - first_cyc), 64'(63));
  endtask

  task automatic run_block(input int gap_after, input int gap_len, input bit garbage);
    push_expected();
    load_words(gap_after, gap_len, garbage);
    wait_done(garbage);
  endtask

  task automatic compare_stream(input string name);
    int mism = 0;
    for (int i = 0; i < 64; i++) if (got_w[i] !== ref_w[i]) mism++;
    check(name, 64'(mism), 64'(0));
  endtask

  task automatic check_buf_zero(input string name);
    logic [36:0] acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | u_dut.u_buf.mem[i];
    check(name, 64'(acc), 64'(0));
  endtask

  // After a block, entry i holds W[48+i] rotated right by the forced amount.
  task automatic check_buf(input string name, input logic [4:0] r);
    logic [36:0] m;
    int mism = 0;
    for (int i = 0; i < 16; i++) begin
      m = u_dut.u_buf.mem[i];
      if (m[36:32] !== r || m[31:0] !== rotr(exp_w[48+i], int'(r))) mism++;
    end
    check(name, 64'(mism), 64'(0));
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready_o), 64'(1));
    check({tag, "_valid"}, 64'(wk_valid_o), 64'(0));
    check({tag, "_w_wk"}, {w_o, wk_o}, 64'(0));
    check({tag, "_round_last"}, 64'({round_o, last_o}), 64'(0));
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
    check_buf_zero({tag, "_buf_zero"});
  endtask

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; in_data_i = '0;
    stall_mode = 1'b0; rnd_fixed_en = 1'b0; rnd_fixed = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    set_abc();
    run_block(0, 0, 1'b0);
    for (int i = 0; i < 5; i++) check("abc_w16_20", 64'(got_w[16+i]), 64'(abc_w16[i]));
    check("abc_wk0", 64'(got_wk[0]), 64'h00000000a3ec9318);
    ref_w = got_w;

    rnd_fixed_en = 1'b1; rnd_fixed = 5'd0;
    run_block(0, 0, 1'b0);
    compare_stream("rnd0_stream");
    check_buf("rnd0_buf", 5'd0);

    rnd_fixed = 5'd31;
    run_block(0, 0, 1'b0);
    compare_stream("rnd31_stream");
    check_buf("rnd31_buf", 5'd31);
    rnd_fixed_en = 1'b0;

    stall_mode = 1'b1;
    run_block(0, 0, 1'b0);
    compare_stream("stall_stream");
    stall_mode = 1'b0;

    // Back-to-back random blocks with in_valid_i held high during RUN.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      run_block(0, 0, 1'b1);
    end

    set_abc();
    push_expected();
    load_words(0, 0, 1'b0);
    for (int c = 0; c < 500 && hs_count < 30; c++) begin
      @(posedge clk); #1;
    end
    check("mid_reset_reach", 64'(hs_count >= 30), 64'(1));
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    check_reset_state("mid_reset");
    rst = 1'b0;
    run_block(0, 0, 1'b0);
    compare_stream("after_reset_stream");

    run_block(7, 20, 1'b0);
    compare_stream("gapped_stream");

    check("queue_empty", 64'(q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
